// File: rtl/rollback_controller.sv
// Rollback arbiter: collects trap/dcache/execute rollback requests, filters wrong-path ones,
// and issues one registered rollback per cycle while tracking per-thread trap mode.
module rollback_controller #(
  parameter int unsigned THREADS       = 4,
  parameter int unsigned SQUASH_CYCLES = 3,
  parameter int unsigned ADDR_WIDTH    = 32,
  localparam int unsigned TW           = $clog2(THREADS)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ix_rollback_en,
  input  logic [ADDR_WIDTH-1:0] ix_rollback_pc,
  input  logic [TW-1:0]         ix_thread_idx,
  input  logic                  ix_is_eret,
  input  logic                  dd_rollback_en,
  input  logic [ADDR_WIDTH-1:0] dd_rollback_pc,
  input  logic [TW-1:0]         dd_thread_idx,
  input  logic                  tr_trap_en,
  input  logic [ADDR_WIDTH-1:0] tr_trap_pc,
  input  logic [TW-1:0]         tr_thread_idx,
  output logic                  wb_rollback_en,
  output logic [TW-1:0]         wb_rollback_thread_idx,
  output logic [ADDR_WIDTH-1:0] wb_rollback_pc,
  output logic                  wb_rollback_is_eret,
  output logic [THREADS-1:0]    wb_in_trap,
  output logic                  rb_dropped
);

  localparam int unsigned CW = $clog2(SQUASH_CYCLES + 1);
  localparam logic [1:0] RANK_TR = 2'd0;
  localparam logic [1:0] RANK_DD = 2'd1;
  localparam logic [1:0] RANK_IX = 2'd2;

  // Deferred per-thread winners and wrong-path squash windows
  logic [THREADS-1:0]    pend_valid;
  logic [THREADS-1:0]    pend_eret;
  logic [1:0]            pend_rank [THREADS];
  logic [ADDR_WIDTH-1:0] pend_pc   [THREADS];
  logic [CW-1:0]         squash_cnt  [THREADS];
  logic [1:0]            squash_rank [THREADS];
  logic [TW-1:0]         rr;
  logic [1:0]            wb_rank;

  logic [THREADS-1:0]    win_valid;
  logic [THREADS-1:0]    win_eret;
  logic [1:0]            win_rank [THREADS];
  logic [ADDR_WIDTH-1:0] win_pc   [THREADS];
  logic                  drop_any;
  logic                  issue;
  logic [TW-1:0]         grant;

  function automatic logic eligible(input logic [CW-1:0] cnt, input logic [1:0] srank,
                                    input logic [1:0] rank);
    return (cnt == '0) || (rank < srank);
  endfunction

  // Per-thread winner: oldest eligible new request, which displaces pending only if strictly older
  always_comb begin : thread_select
    logic                  tr_hit, dd_hit, ix_hit;
    logic                  new_valid, take_new;
    logic [1:0]            new_rank;
    logic [ADDR_WIDTH-1:0] new_pc;
    logic                  new_eret;
    drop_any = 1'b0;
    win_valid = '0;
    win_eret  = '0;
    for (int t = 0; t < THREADS; t++) begin
      win_rank[t] = '0;
      win_pc[t]   = '0;
      tr_hit = tr_trap_en     && (tr_thread_idx == TW'(t));
      dd_hit = dd_rollback_en && (dd_thread_idx == TW'(t));
      ix_hit = ix_rollback_en && (ix_thread_idx == TW'(t));
      new_valid = 1'b0;
      new_rank  = '0;
      new_pc    = '0;
      new_eret  = 1'b0;
      if (tr_hit && eligible(squash_cnt[t], squash_rank[t], RANK_TR)) begin
        new_valid = 1'b1;
        new_rank  = RANK_TR;
        new_pc    = tr_trap_pc;
      end else if (dd_hit && eligible(squash_cnt[t], squash_rank[t], RANK_DD)) begin
        new_valid = 1'b1;
        new_rank  = RANK_DD;
        new_pc    = dd_rollback_pc;
      end else if (ix_hit && eligible(squash_cnt[t], squash_rank[t], RANK_IX)) begin
        new_valid = 1'b1;
        new_rank  = RANK_IX;
        new_pc    = ix_rollback_pc;
        new_eret  = ix_is_eret;
      end
      take_new = new_valid && (!pend_valid[t] || (new_rank < pend_rank[t]));
      if (take_new) begin
        win_valid[t] = 1'b1;
        win_rank[t]  = new_rank;
        win_pc[t]    = new_pc;
        win_eret[t]  = new_eret;
      end else if (pend_valid[t]) begin
        win_valid[t] = 1'b1;
        win_rank[t]  = pend_rank[t];
        win_pc[t]    = pend_pc[t];
        win_eret[t]  = pend_eret[t];
      end
      if ((tr_hit && !(take_new && new_rank == RANK_TR)) ||
          (dd_hit && !(take_new && new_rank == RANK_DD)) ||
          (ix_hit && !(take_new && new_rank == RANK_IX)))
        drop_any = 1'b1;
    end
  end

  // Round-robin pick among threads with a winner, starting at rr
  always_comb begin : arbitrate
    logic [TW-1:0] cand;
    issue = 1'b0;
    grant = '0;
    for (int i = 0; i < THREADS; i++) begin
      cand = rr + TW'(i);
      if (!issue && win_valid[cand]) begin
        issue = 1'b1;
        grant = cand;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wb_rollback_en         <= 1'b0;
      wb_rollback_thread_idx <= '0;
      wb_rollback_pc         <= '0;
      wb_rollback_is_eret    <= 1'b0;
      wb_in_trap             <= '0;
      rb_dropped             <= 1'b0;
      wb_rank                <= '0;
      rr                     <= '0;
      pend_valid             <= '0;
      pend_eret              <= '0;
      for (int t = 0; t < THREADS; t++) begin
        pend_rank[t]   <= '0;
        pend_pc[t]     <= '0;
        squash_cnt[t]  <= '0;
        squash_rank[t] <= '0;
      end
    end else begin
      wb_rollback_en      <= issue;
      wb_rollback_is_eret <= issue && win_eret[grant];
      rb_dropped          <= drop_any;
      if (issue) begin
        wb_rollback_thread_idx <= grant;
        wb_rollback_pc         <= win_pc[grant];
        wb_rank                <= win_rank[grant];
        rr                     <= grant + TW'(1);
      end
      // Trap mode follows the rollback already presented on wb_*
      if (wb_rollback_en) begin
        if (wb_rank == RANK_TR)
          wb_in_trap[wb_rollback_thread_idx] <= 1'b1;
        else if (wb_rollback_is_eret)
          wb_in_trap[wb_rollback_thread_idx] <= 1'b0;
      end
      for (int t = 0; t < THREADS; t++) begin
        pend_valid[t] <= win_valid[t] && !(issue && grant == TW'(t));
        if (win_valid[t]) begin
          pend_rank[t] <= win_rank[t];
          pend_pc[t]   <= win_pc[t];
          pend_eret[t] <= win_eret[t];
        end
        if (issue && grant == TW'(t)) begin
          squash_cnt[t]  <= CW'(SQUASH_CYCLES);
          squash_rank[t] <= win_rank[t];
        end else if (squash_cnt[t] != '0) begin
          squash_cnt[t] <= squash_cnt[t] - CW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_rollback_controller.sv
// Directed bench for rollback_controller: squash window, rank priority, round-robin deferral,
// trap-mode flag and mid-run reset, with hand-computed expectations.
module tb_rollback_controller;

  localparam int unsigned THREADS = 4;
  localparam int unsigned AW      = 32;
  localparam int unsigned TW      = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          ix_rollback_en, ix_is_eret, dd_rollback_en, tr_trap_en;
  logic [AW-1:0] ix_rollback_pc, dd_rollback_pc, tr_trap_pc;
  logic [TW-1:0] ix_thread_idx, dd_thread_idx, tr_thread_idx;
  logic          wb_rollback_en, wb_rollback_is_eret, rb_dropped;
  logic [TW-1:0] wb_rollback_thread_idx;
  logic [AW-1:0] wb_rollback_pc;
  logic [THREADS-1:0] wb_in_trap;

  int checks = 0;
  int errors = 0;

  rollback_controller #(.THREADS(THREADS), .SQUASH_CYCLES(3), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .reset(reset),
    .ix_rollback_en(ix_rollback_en), .ix_rollback_pc(ix_rollback_pc),
    .ix_thread_idx(ix_thread_idx), .ix_is_eret(ix_is_eret),
    .dd_rollback_en(dd_rollback_en), .dd_rollback_pc(dd_rollback_pc),
    .dd_thread_idx(dd_thread_idx),
    .tr_trap_en(tr_trap_en), .tr_trap_pc(tr_trap_pc), .tr_thread_idx(tr_thread_idx),
    .wb_rollback_en(wb_rollback_en), .wb_rollback_thread_idx(wb_rollback_thread_idx),
    .wb_rollback_pc(wb_rollback_pc), .wb_rollback_is_eret(wb_rollback_is_eret),
    .wb_in_trap(wb_in_trap), .rb_dropped(rb_dropped)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    ix_rollback_en = 1'b0; ix_is_eret = 1'b0; ix_rollback_pc = '0; ix_thread_idx = '0;
    dd_rollback_en = 1'b0; dd_rollback_pc = '0; dd_thread_idx = '0;
    tr_trap_en = 1'b0; tr_trap_pc = '0; tr_thread_idx = '0;
  endtask

  task automatic req_ix(input logic [TW-1:0] t, input logic [AW-1:0] pc, input logic eret);
    ix_rollback_en = 1'b1; ix_thread_idx = t; ix_rollback_pc = pc; ix_is_eret = eret;
  endtask

  task automatic req_dd(input logic [TW-1:0] t, input logic [AW-1:0] pc);
    dd_rollback_en = 1'b1; dd_thread_idx = t; dd_rollback_pc = pc;
  endtask

  task automatic req_tr(input logic [TW-1:0] t, input logic [AW-1:0] pc);
    tr_trap_en = 1'b1; tr_thread_idx = t; tr_trap_pc = pc;
  endtask

  task automatic expect_issue(input string tag, input logic [TW-1:0] t, input logic [AW-1:0] pc,
                              input logic eret, input logic drop);
    check({tag, "_en"}, 64'(wb_rollback_en), 64'd1);
    check({tag, "_thr"}, 64'(wb_rollback_thread_idx), 64'(t));
    check({tag, "_pc"}, 64'(wb_rollback_pc), 64'(pc));
    check({tag, "_eret"}, 64'(wb_rollback_is_eret), 64'(eret));
    check({tag, "_drop"}, 64'(rb_dropped), 64'(drop));
  endtask

  task automatic expect_none(input string tag, input logic drop);
    check({tag, "_en"}, 64'(wb_rollback_en), 64'd0);
    check({tag, "_drop"}, 64'(rb_dropped), 64'(drop));
  endtask

  task automatic expect_reset_state(input string tag);
    check({tag, "_en"}, 64'(wb_rollback_en), 64'd0);
    check({tag, "_thr"}, 64'(wb_rollback_thread_idx), 64'd0);
    check({tag, "_pc"}, 64'(wb_rollback_pc), 64'd0);
    check({tag, "_eret"}, 64'(wb_rollback_is_eret), 64'd0);
    check({tag, "_trap"}, 64'(wb_in_trap), 64'd0);
    check({tag, "_drop"}, 64'(rb_dropped), 64'd0);
  endtask

  task automatic wait_idle(input int n);
    idle();
    repeat (n) step();
  endtask

  initial begin
    reset = 1'b1;
    idle();
    step(); step();
    expect_reset_state("rst");
    reset = 1'b0;
    step();

    // Squash window: same-thread ix requests dropped for three cycles after an issue
    req_ix(2'd2, 32'h1000, 1'b0);
    step(); expect_issue("sq_first", 2'd2, 32'h1000, 1'b0, 1'b0);
    req_ix(2'd2, 32'h1004, 1'b0);
    step(); expect_none("sq_d1", 1'b1);
    req_ix(2'd2, 32'h1008, 1'b0);
    step(); expect_none("sq_d2", 1'b1);
    req_ix(2'd2, 32'h100c, 1'b0);
    step(); expect_none("sq_d3", 1'b1);
    req_ix(2'd2, 32'h1010, 1'b0);
    step(); expect_issue("sq_after", 2'd2, 32'h1010, 1'b0, 1'b0);
    idle();
    step(); expect_none("sq_idle", 1'b0);
    wait_idle(3);

    // Trap beats same-thread ix; trap flag follows one cycle after issue (rr -> 2)
    req_tr(2'd1, 32'h8000);
    req_ix(2'd1, 32'h0040, 1'b0);
    step(); expect_issue("trap_ix", 2'd1, 32'h8000, 1'b0, 1'b1);
    idle();
    step(); check("trap_flag", 64'(wb_in_trap), 64'h2);
    wait_idle(3);

    // Move rr to 0 by issuing to thread 3, then cross-thread deferral
    req_ix(2'd3, 32'h0700, 1'b0);
    step(); expect_issue("rr_prep", 2'd3, 32'h0700, 1'b0, 1'b0);
    wait_idle(3);
    req_dd(2'd3, 32'h0200);
    req_ix(2'd0, 32'h0300, 1'b0);
    step(); expect_issue("rr_first", 2'd0, 32'h0300, 1'b0, 1'b0);
    idle();
    step(); expect_issue("rr_defer", 2'd3, 32'h0200, 1'b0, 1'b0);
    wait_idle(3);

    // Eret leaves trap mode (rr 0 -> 2)
    req_ix(2'd1, 32'h0500, 1'b1);
    step(); expect_issue("eret", 2'd1, 32'h0500, 1'b1, 1'b0);
    idle();
    step(); check("eret_flag", 64'(wb_in_trap), 64'h0);
    wait_idle(3);

    // Eret on a thread not in trap still issues, flag stays clear (rr -> 1)
    req_ix(2'd0, 32'h0600, 1'b1);
    step(); expect_issue("eret_idle", 2'd0, 32'h0600, 1'b1, 1'b0);
    idle();
    step(); check("eret_idle_flag", 64'(wb_in_trap), 64'h0);
    wait_idle(3);

    // Pending replacement: rr -> 3, then three threads request at once
    req_ix(2'd2, 32'h0900, 1'b0);
    step(); expect_issue("pend_prep", 2'd2, 32'h0900, 1'b0, 1'b0);
    wait_idle(3);
    req_tr(2'd3, 32'h0000_a000);
    req_dd(2'd0, 32'h0020);
    req_ix(2'd2, 32'h0010, 1'b0);
    step(); expect_issue("pend_a", 2'd3, 32'h0000_a000, 1'b0, 1'b0);
    idle();
    req_tr(2'd2, 32'h8000);
    step(); expect_issue("pend_b", 2'd0, 32'h0020, 1'b0, 1'b0);
    idle();
    step(); expect_issue("pend_c", 2'd2, 32'h8000, 1'b0, 1'b0);
    step();
    expect_none("pend_done", 1'b0);
    check("pend_flags", 64'(wb_in_trap), 64'hc);
    wait_idle(3);

    // Mid-run reset with pending entries and an active squash window (rr = 3)
    req_tr(2'd0, 32'h0050);
    req_dd(2'd1, 32'h0060);
    req_ix(2'd3, 32'h0070, 1'b0);
    step(); expect_issue("mrst_pre", 2'd3, 32'h0070, 1'b0, 1'b0);
    idle();
    #1 reset = 1'b1;
    #1 expect_reset_state("mrst");
    reset = 1'b0;
    req_ix(2'd3, 32'h0044, 1'b0);
    step(); expect_issue("mrst_post", 2'd3, 32'h0044, 1'b0, 1'b0);
    idle();
    step(); expect_none("mrst_clean", 1'b0);
    check("mrst_flags", 64'(wb_in_trap), 64'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
